// File: rtl/isa_pkg.sv
// isa_pkg: shared definitions for the 16-bit custom-ISA CPU.
//   - Opcode constants used by the sequencer and the ALU.
//   - Sequencer state encoding (exposed on the sequencer's dbg_state port).
//   - Instruction field bit positions.
//   - op_writes_rf(): true for opcodes that write the register file.
package isa_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LD   = 4'h1;
    localparam logic [3:0] OP_JMP  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam int INSTR_W   = 16;
    localparam int FIELD_W   = 4;
    localparam int IMM_W     = 8;
    localparam int OPC_LSB   = 12;
    localparam int LD_RD_LSB = 8;
    localparam int RD_LSB    = 4;
    localparam int RS_LSB    = 0;
    localparam int IMM_LSB   = 0;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    // LD and the ALU range 0x2..0xD write back; NOP, JMP and HALT do not.
    function automatic logic op_writes_rf(input logic [3:0] op);
        return (op != OP_NOP) && (op != OP_JMP) && (op != OP_HALT);
    endfunction

endpackage

// File: rtl/instr_fields.sv
// instr_fields: combinational field extraction from the instruction register.
// Ports:
//   i_instr  in  16  captured instruction word
//   o_opcode out 4   instr[15:12]
//   o_rd     out 4   instr[11:8] for LD, instr[7:4] for every other opcode
//   o_rs     out 4   instr[3:0]
//   o_imm    out 8   instr[7:0]
module instr_fields
    import isa_pkg::*;
(
    input  logic [INSTR_W-1:0] i_instr,
    output logic [FIELD_W-1:0] o_opcode,
    output logic [FIELD_W-1:0] o_rd,
    output logic [FIELD_W-1:0] o_rs,
    output logic [IMM_W-1:0]   o_imm
);

    logic [FIELD_W-1:0] w_opcode;

    assign w_opcode = i_instr[OPC_LSB +: FIELD_W];
    assign o_opcode = w_opcode;
    // LD uses the low byte as its immediate, so its destination moves up a nibble.
    assign o_rd     = (w_opcode == OP_LD) ? i_instr[LD_RD_LSB +: FIELD_W]
                                          : i_instr[RD_LSB +: FIELD_W];
    assign o_rs     = i_instr[RS_LSB +: FIELD_W];
    assign o_imm    = i_instr[IMM_LSB +: IMM_W];

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle FETCH/DECODE/EXEC/WB sequencer for the 16-bit CPU.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   run, step           free-run level / single-step pulse (start from IDLE)
//   imem_rd, imem_addr  fetch request (held until imem_valid), address = pc
//   imem_valid, imem_data  instruction return
//   rf_rd_addr, rf_rs_addr, rf_rd_data, rf_rs_data  register file reads
//   alu_op, alu_a, alu_b, alu_y  combinational ALU interface
//   rf_wr_en, rf_wr_addr, rf_wr_data  one-cycle write-back strobe
//   pc, busy, halted    status
//   dbg_state           current FSM state (isa_pkg::state_t encoding)
// Handshake: a fetch completes on the first clock edge in FETCH where
// imem_rd and imem_valid are both high; imem_valid in any other state is ignored.
module cpu_sequencer
    import isa_pkg::*;
#(
    parameter int PC_W   = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              step,
    output logic              imem_rd,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_valid,
    input  logic [15:0]       imem_data,
    output logic [3:0]        rf_rd_addr,
    output logic [3:0]        rf_rs_addr,
    input  logic [DATA_W-1:0] rf_rd_data,
    input  logic [DATA_W-1:0] rf_rs_data,
    output logic [3:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_y,
    output logic              rf_wr_en,
    output logic [3:0]        rf_wr_addr,
    output logic [DATA_W-1:0] rf_wr_data,
    output logic [PC_W-1:0]   pc,
    output logic              busy,
    output logic              halted,
    output logic [2:0]        dbg_state
);

    state_t              r_state;
    logic [PC_W-1:0]     r_pc;
    logic [15:0]         r_ir;
    logic                r_imem_rd;
    logic                r_wr_en;
    logic [3:0]          r_wr_addr;
    logic [DATA_W-1:0]   r_wr_data;
    logic                r_busy;
    logic                r_halted;

    logic [3:0]          w_opcode;
    logic [3:0]          w_rd;
    logic [3:0]          w_rs;
    logic [7:0]          w_imm;

    instr_fields u_fields (
        .i_instr  (r_ir),
        .o_opcode (w_opcode),
        .o_rd     (w_rd),
        .o_rs     (w_rs),
        .o_imm    (w_imm)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pc      <= '0;
            r_ir      <= '0;
            r_imem_rd <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_busy    <= 1'b0;
            r_halted  <= 1'b0;
        end else begin
            // Write strobe is only ever set on the EXEC->WB edge, so it lasts one cycle.
            r_wr_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (run || step) begin
                        r_state   <= S_FETCH;
                        r_imem_rd <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (imem_valid) begin
                        r_ir      <= imem_data;
                        r_imem_rd <= 1'b0;
                        r_state   <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    // Register addresses come straight off r_ir; reads settle this cycle.
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    if (w_opcode == OP_HALT) begin
                        r_state  <= S_HALT;
                        r_busy   <= 1'b0;
                        r_halted <= 1'b1;
                    end else begin
                        r_state <= S_WB;
                        if (op_writes_rf(w_opcode)) begin
                            r_wr_en   <= 1'b1;
                            r_wr_addr <= w_rd;
                            r_wr_data <= (w_opcode == OP_LD) ? DATA_W'(w_imm) : alu_y;
                        end
                    end
                end
                S_WB: begin
                    r_pc <= (w_opcode == OP_JMP) ? PC_W'(w_imm) : r_pc + PC_W'(1);
                    if (run) begin
                        r_state   <= S_FETCH;
                        r_imem_rd <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_imem_rd <= 1'b0;
                    r_busy    <= 1'b0;
                    r_halted  <= 1'b0;
                end
            endcase
        end
    end

    assign imem_rd    = r_imem_rd;
    assign imem_addr  = r_pc;
    assign pc         = r_pc;
    assign rf_rd_addr = w_rd;
    assign rf_rs_addr = w_rs;
    assign alu_op     = w_opcode;
    assign alu_a      = rf_rd_data;
    assign alu_b      = rf_rs_data;
    assign rf_wr_en   = r_wr_en;
    assign rf_wr_addr = r_wr_addr;
    assign rf_wr_data = r_wr_data;
    assign busy       = r_busy;
    assign halted     = r_halted;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: self-checking bench for cpu_sequencer. The bench plays the
// instruction ROM, the 16x8 register file and the ALU, and keeps an
// instruction-level reference model that predicts writes, pc and cycle counts.
module tb_cpu_sequencer;
    import isa_pkg::*;

    localparam int PC_W   = 8;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst, run, step;
    logic              imem_rd, imem_valid;
    logic [PC_W-1:0]   imem_addr;
    logic [15:0]       imem_data;
    logic [3:0]        rf_rd_addr, rf_rs_addr, alu_op, rf_wr_addr;
    logic [DATA_W-1:0] rf_rd_data, rf_rs_data, alu_a, alu_b, alu_y, rf_wr_data;
    logic              rf_wr_en, busy, halted;
    logic [PC_W-1:0]   pc;
    logic [2:0]        dbg_state;

    always #5 clk = ~clk;

    cpu_sequencer #(.PC_W(PC_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .run(run), .step(step),
        .imem_rd(imem_rd), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_data(imem_data),
        .rf_rd_addr(rf_rd_addr), .rf_rs_addr(rf_rs_addr),
        .rf_rd_data(rf_rd_data), .rf_rs_data(rf_rs_data),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
        .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
        .pc(pc), .busy(busy), .halted(halted), .dbg_state(dbg_state)
    );

    // ---------------- environment: ROM, register file, ALU ----------------
    logic [15:0] mem      [0:255];
    logic [7:0]  env_regs [0:15];
    int          fetch_delay = 0;
    bit          noise_en    = 1'b0;
    int          wait_cnt    = 0;

    function automatic logic [7:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            4'h2: return a + b;
            4'h3: return a - b;
            4'h4: return a & b;
            4'h5: return a | b;
            4'h6: return a ^ b;
            4'h7: return ~a;
            4'h8: return a << 1;
            4'h9: return a >> 1;
            default: return a + b + {4'h0, op};
        endcase
    endfunction

    assign rf_rd_data = env_regs[rf_rd_addr];
    assign rf_rs_data = env_regs[rf_rs_addr];
    assign alu_y      = alu_fn(alu_op, alu_a, alu_b);

    // ROM responder: valid after fetch_delay wait cycles; optional junk outside fetches.
    initial begin
        imem_valid = 1'b0;
        imem_data  = 16'h0;
        forever begin
            @(negedge clk);
            if (imem_rd === 1'b1) begin
                if (wait_cnt >= fetch_delay) begin
                    imem_valid = 1'b1;
                    imem_data  = mem[imem_addr];
                end else begin
                    imem_valid = 1'b0;
                    imem_data  = 16'($urandom);
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
                if (noise_en) begin
                    imem_valid = 1'($urandom_range(0, 1));
                    imem_data  = 16'($urandom);
                end else begin
                    imem_valid = 1'b0;
                    imem_data  = 16'h0;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [11:0] exp_q[$];
    int          n_cmp  = 0;
    int          n_err  = 0;
    int          wr_cnt = 0;
    bit          prev_wr = 1'b0;

    initial begin
        logic [11:0] e;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1 && rf_wr_en === 1'b1) begin
                wr_cnt++;
                n_cmp++;
                if (prev_wr) begin
                    n_err++;
                    $display("FAIL wr_en_width: got 2 consecutive cycles expected 1");
                end
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_write: got r%0h<=%0h expected no write", rf_wr_addr, rf_wr_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({rf_wr_addr, rf_wr_data} !== e) begin
                        n_err++;
                        $display("FAIL write: got r%0h<=%0h expected r%0h<=%0h", rf_wr_addr, rf_wr_data, e[11:8], e[7:0]);
                    end
                end
                env_regs[rf_wr_addr] = rf_wr_data;
            end
            prev_wr = (rst !== 1'b1) && (rf_wr_en === 1'b1);
        end
    end

    // ---------------- reference model (instruction level) ----------------
    logic [7:0] m_regs [0:15];
    logic [7:0] m_pc;
    bit         m_halted;
    int         m_exec;

    task automatic model_run(input int max_n);
        logic [15:0] ins;
        logic [3:0]  op, rd, rs;
        logic [7:0]  y;
        int          n;
        n = 0;
        while (!m_halted && n < max_n) begin
            ins = mem[m_pc];
            op  = ins[15:12];
            if (op == 4'hF) begin
                m_halted = 1'b1;
            end else begin
                if (op == 4'h1) begin
                    rd = ins[11:8];
                    m_regs[rd] = ins[7:0];
                    exp_q.push_back({rd, ins[7:0]});
                end else if (op >= 4'h2 && op <= 4'hD) begin
                    rd = ins[7:4];
                    rs = ins[3:0];
                    y  = alu_fn(op, m_regs[rd], m_regs[rs]);
                    m_regs[rd] = y;
                    exp_q.push_back({rd, y});
                end
                m_pc = (op == 4'hE) ? ins[7:0] : m_pc + 8'd1;
                m_exec++;
            end
            n++;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic reset_dut();
        rst  = 1'b1;
        run  = 1'b0;
        step = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        m_pc     = 8'h00;
        m_halted = 1'b0;
        m_exec   = 0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    endtask

    task automatic init_regs();
        logic [7:0] v;
        for (int i = 0; i < 16; i++) begin
            v = 8'($urandom);
            env_regs[i] = v;
            m_regs[i]   = v;
        end
    endtask

    task automatic step_once(input int settle);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        repeat (settle) @(negedge clk);
    endtask

    task automatic run_until_halt(output int cyc);
        cyc = 0;
        while (halted !== 1'b1 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (halted !== 1'b1) begin
            n_err++;
            $display("FAIL halt_timeout: got halted=%0b expected 1 within 2000 cycles", halted);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clear_mem();
        init_regs();
        reset_dut();
        run = 1'b1;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        run = 1'b0;
        @(negedge clk);
        n_cmp++; if (dbg_state !== 3'(S_IDLE)) begin n_err++; $display("FAIL rst_state: got %0d expected %0d", dbg_state, S_IDLE); end
        n_cmp++; if (pc !== 8'h00) begin n_err++; $display("FAIL rst_pc: got %0h expected 0", pc); end
        n_cmp++; if (imem_rd !== 1'b0) begin n_err++; $display("FAIL rst_imem_rd: got %0b expected 0", imem_rd); end
        n_cmp++; if (imem_addr !== 8'h00) begin n_err++; $display("FAIL rst_imem_addr: got %0h expected 0", imem_addr); end
        n_cmp++; if (rf_wr_en !== 1'b0) begin n_err++; $display("FAIL rst_wr_en: got %0b expected 0", rf_wr_en); end
        n_cmp++; if (rf_wr_addr !== 4'h0) begin n_err++; $display("FAIL rst_wr_addr: got %0h expected 0", rf_wr_addr); end
        n_cmp++; if (rf_wr_data !== 8'h00) begin n_err++; $display("FAIL rst_wr_data: got %0h expected 0", rf_wr_data); end
        n_cmp++; if (alu_op !== 4'h0) begin n_err++; $display("FAIL rst_alu_op: got %0h expected 0", alu_op); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %0b expected 0", busy); end
        n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL rst_halted: got %0b expected 0", halted); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ld();
        int cyc;
        clear_mem();
        init_regs();
        fetch_delay = 0;
        noise_en    = 1'b0;
        mem[0] = 16'h1A3C;
        mem[1] = 16'hF000;
        reset_dut();
        model_run(100);
        run = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            n_cmp++;
            if (rf_wr_en !== (k == 4)) begin n_err++; $display("FAIL ld_wr_en_cycle%0d: got %0b expected %0b", k, rf_wr_en, (k == 4)); end
            if (k == 4) begin
                n_cmp++; if (rf_wr_addr !== 4'hA) begin n_err++; $display("FAIL ld_wr_addr: got %0h expected a", rf_wr_addr); end
                n_cmp++; if (rf_wr_data !== 8'h3C) begin n_err++; $display("FAIL ld_wr_data: got %0h expected 3c", rf_wr_data); end
            end
            if (k == 5) begin
                n_cmp++; if (pc !== 8'h01) begin n_err++; $display("FAIL ld_pc: got %0h expected 1", pc); end
            end
        end
        run_until_halt(cyc);
        run = 1'b0;
        n_cmp++; if (pc !== m_pc) begin n_err++; $display("FAIL ld_halt_pc: got %0h expected %0h", pc, m_pc); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ld_halt_busy: got %0b expected 0", busy); end
    endtask

    task automatic test_alu();
        int cyc;
        clear_mem();
        init_regs();
        mem[0] = 16'h1A3C;
        mem[1] = 16'h2021;
        mem[2] = 16'hF000;
        env_regs[2] = 8'd5; m_regs[2] = 8'd5;
        env_regs[1] = 8'd3; m_regs[1] = 8'd3;
        reset_dut();
        model_run(100);
        run = 1'b1;
        run_until_halt(cyc);
        run = 1'b0;
        n_cmp++; if (cyc != 12) begin n_err++; $display("FAIL alu_cycles: got %0d expected 12", cyc); end
        n_cmp++; if (env_regs[2] !== 8'h08) begin n_err++; $display("FAIL alu_r2: got %0h expected 08", env_regs[2]); end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL alu_pending: got %0d expected 0", exp_q.size()); end
    endtask

    task automatic test_random_programs();
        int          cyc, len, kind;
        logic [3:0]  op;
        for (int it = 0; it < 4; it++) begin
            clear_mem();
            init_regs();
            fetch_delay = $urandom_range(0, 3);
            noise_en    = 1'b1;
            len = $urandom_range(8, 20);
            for (int i = 0; i < len; i++) begin
                kind = $urandom_range(0, 9);
                if (kind == 0)      mem[i] = {4'h0, 12'($urandom)};
                else if (kind <= 3) mem[i] = {4'h1, 12'($urandom)};
                else if (kind <= 8) begin
                    op = 4'($urandom_range(2, 13));
                    mem[i] = {op, 12'($urandom)};
                end else            mem[i] = {4'hE, 4'($urandom), 8'($urandom_range(i + 1, len))};
            end
            mem[len] = {4'hF, 12'($urandom)};
            reset_dut();
            model_run(1000);
            run = 1'b1;
            run_until_halt(cyc);
            run = 1'b0;
            n_cmp++; if (cyc != (m_exec + 1) * (4 + fetch_delay)) begin n_err++; $display("FAIL rand%0d_cycles: got %0d expected %0d", it, cyc, (m_exec + 1) * (4 + fetch_delay)); end
            n_cmp++; if (pc !== m_pc) begin n_err++; $display("FAIL rand%0d_pc: got %0h expected %0h", it, pc, m_pc); end
            n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rand%0d_pending: got %0d expected 0", it, exp_q.size()); end
            n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rand%0d_busy: got %0b expected 0", it, busy); end
        end
        noise_en    = 1'b0;
        fetch_delay = 0;
    endtask

    task automatic test_step();
        int w0, t;
        clear_mem();
        init_regs();
        mem[0] = 16'h1577;
        mem[1] = 16'h1688;
        reset_dut();
        model_run(1);
        w0 = wr_cnt;
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL step_busy: got %0b expected 1", busy); end
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        t = 0;
        while (busy === 1'b1 && t < 50) begin @(negedge clk); t++; end
        repeat (6) @(negedge clk);
        n_cmp++; if (wr_cnt - w0 != 1) begin n_err++; $display("FAIL step_writes: got %0d expected 1", wr_cnt - w0); end
        n_cmp++; if (pc !== m_pc) begin n_err++; $display("FAIL step_pc: got %0h expected %0h", pc, m_pc); end
        n_cmp++; if (dbg_state !== 3'(S_IDLE)) begin n_err++; $display("FAIL step_state: got %0d expected %0d", dbg_state, S_IDLE); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL step_idle_busy: got %0b expected 0", busy); end
    endtask

    task automatic test_jmp_wrap();
        int w0;
        clear_mem();
        init_regs();
        mem[0]   = 16'hE0FF;
        mem[255] = 16'h0000;
        reset_dut();
        w0 = wr_cnt;
        model_run(1);
        step_once(6);
        n_cmp++; if (pc !== m_pc) begin n_err++; $display("FAIL jmp_ff: got %0h expected %0h", pc, m_pc); end
        model_run(1);
        step_once(6);
        n_cmp++; if (pc !== m_pc) begin n_err++; $display("FAIL wrap_pc: got %0h expected %0h", pc, m_pc); end
        mem[0] = 16'hE040;
        model_run(1);
        step_once(6);
        n_cmp++; if (pc !== m_pc) begin n_err++; $display("FAIL jmp_40: got %0h expected %0h", pc, m_pc); end
        n_cmp++; if (wr_cnt != w0) begin n_err++; $display("FAIL jmp_no_write: got %0d writes expected 0", wr_cnt - w0); end
    endtask

    task automatic test_stall_halt();
        clear_mem();
        init_regs();
        fetch_delay = 3;
        noise_en    = 1'b1;
        mem[0] = 16'h1A3C;
        mem[1] = 16'hF000;
        reset_dut();
        model_run(1);
        step = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            step = 1'b0;
            n_cmp++; if (imem_rd !== (k <= 4)) begin n_err++; $display("FAIL stall_imem_rd_c%0d: got %0b expected %0b", k, imem_rd, (k <= 4)); end
            n_cmp++; if (rf_wr_en !== (k == 7)) begin n_err++; $display("FAIL stall_wr_en_c%0d: got %0b expected %0b", k, rf_wr_en, (k == 7)); end
        end
        n_cmp++; if (pc !== m_pc) begin n_err++; $display("FAIL stall_pc: got %0h expected %0h", pc, m_pc); end
        model_run(1);
        step_once(10);
        n_cmp++; if (halted !== 1'b1) begin n_err++; $display("FAIL halt_flag: got %0b expected 1", halted); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL halt_busy: got %0b expected 0", busy); end
        n_cmp++; if (dbg_state !== 3'(S_HALT)) begin n_err++; $display("FAIL halt_state: got %0d expected %0d", dbg_state, S_HALT); end
        step_once(10);
        n_cmp++; if (dbg_state !== 3'(S_HALT)) begin n_err++; $display("FAIL halt_step_state: got %0d expected %0d", dbg_state, S_HALT); end
        n_cmp++; if (pc !== m_pc) begin n_err++; $display("FAIL halt_step_pc: got %0h expected %0h", pc, m_pc); end
        n_cmp++; if (imem_rd !== 1'b0) begin n_err++; $display("FAIL halt_step_rd: got %0b expected 0", imem_rd); end
        fetch_delay = 0;
        noise_en    = 1'b0;
    endtask

    task automatic test_reset_mid_exec();
        int w0;
        clear_mem();
        init_regs();
        mem[0] = 16'h1A3C;
        reset_dut();
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (dbg_state !== 3'(S_EXEC)) begin n_err++; $display("FAIL abort_in_exec: got %0d expected %0d", dbg_state, S_EXEC); end
        w0  = wr_cnt;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (rf_wr_en !== 1'b0) begin n_err++; $display("FAIL abort_wr_en: got %0b expected 0", rf_wr_en); end
        repeat (5) @(negedge clk);
        n_cmp++; if (wr_cnt != w0) begin n_err++; $display("FAIL abort_writes: got %0d expected 0", wr_cnt - w0); end
        n_cmp++; if (pc !== 8'h00) begin n_err++; $display("FAIL abort_pc: got %0h expected 0", pc); end
        n_cmp++; if (dbg_state !== 3'(S_IDLE)) begin n_err++; $display("FAIL abort_state: got %0d expected %0d", dbg_state, S_IDLE); end
    endtask

    task automatic test_run_drop();
        int w0, t;
        clear_mem();
        init_regs();
        mem[0] = 16'h1101;
        mem[1] = 16'h1202;
        mem[2] = 16'h1303;
        mem[3] = 16'hF000;
        reset_dut();
        model_run(2);
        w0  = wr_cnt;
        run = 1'b1;
        t = 0;
        while (rf_wr_en !== 1'b1 && t < 50) begin @(negedge clk); t++; end
        n_cmp++; if (t != 4) begin n_err++; $display("FAIL drop_first_wb: got cycle %0d expected 4", t); end
        @(negedge clk);
        @(negedge clk);
        run = 1'b0;
        t = 0;
        while (busy === 1'b1 && t < 50) begin @(negedge clk); t++; end
        repeat (4) @(negedge clk);
        n_cmp++; if (wr_cnt - w0 != 2) begin n_err++; $display("FAIL drop_writes: got %0d expected 2", wr_cnt - w0); end
        n_cmp++; if (pc !== m_pc) begin n_err++; $display("FAIL drop_pc: got %0h expected %0h", pc, m_pc); end
        n_cmp++; if (dbg_state !== 3'(S_IDLE)) begin n_err++; $display("FAIL drop_state: got %0d expected %0d", dbg_state, S_IDLE); end
    endtask

    initial begin
        rst  = 1'b1;
        run  = 1'b0;
        step = 1'b0;
        test_reset();
        test_ld();
        test_alu();
        test_step();
        test_jmp_wrap();
        test_stall_halt();
        test_reset_mid_exec();
        test_run_drop();
        test_random_programs();
        n_cmp++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL final_pending: got %0d expected 0", exp_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle instruction sequencer for the 16-bit custom-ISA CPU. It fetches an instruction word from instruction memory, splits it into opcode, register and immediate fields, and drives the register file and ALU through read, execute and write-back. It supports free-run and single-step (button) modes. It sits between the instruction ROM, the 16x8 register file and the combinational ALU.

## Interface
Parameters:
- PC_W, 8: program counter and instruction-memory address width.
- DATA_W, 8: register and ALU data width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  level; 1 = free-run, 0 = single-step.
- step  in  1  one-cycle pulse (already debounced); starts one instruction when idle.
- imem_rd  out  1  fetch request, held until imem_valid.
- imem_addr  out  PC_W  fetch address (= pc).
- imem_valid  in  1  instruction word valid this cycle.
- imem_data  in  16  instruction word.
- rf_rd_addr  out  4  destination/first-operand read address.
- rf_rs_addr  out  4  source read address.
- rf_rd_data, rf_rs_data  in  DATA_W  combinational register reads.
- alu_op  out  4  opcode to ALU.
- alu_a, alu_b  out  DATA_W  operands (rd data, rs data).
- alu_y  in  DATA_W  combinational ALU result.
- rf_wr_en  out  1  one-cycle write strobe.
- rf_wr_addr  out  4; rf_wr_data  out  DATA_W.
- pc  out  PC_W  current program counter.
- busy  out  1  high in any state except IDLE/HALT.
- halted  out  1  high in HALT.

## Operation
- Fields: opcode = instr[15:12]; imm = instr[7:0]; rs = instr[3:0]; rd = instr[11:8] when opcode = 0x1 (LD), otherwise instr[7:4].
- Opcodes: 0x0 NOP; 0x1 LD rd,#imm (rd <- imm); 0x2–0xD ALU ops (rd <- alu_y); 0xE JMP #imm (pc <- imm, no write); 0xF HALT.
- FSM: IDLE -> FETCH when run=1 or step=1.
- FETCH: imem_rd=1 until imem_valid, then capture imem_data into the instruction register and go to DECODE.
- DECODE: drive rf_rd_addr/rf_rs_addr from the captured fields, then go to EXEC.
- EXEC: register the result (imm for LD, alu_y for ALU ops), then go to WB. HALT goes to HALT directly; NOP/JMP go to WB with no write.
- WB: rf_wr_en=1 for LD/ALU ops. Update pc (JMP: imm; else pc+1). Go to FETCH if run=1, else IDLE.
- HALT: terminal; only rst leaves it.
- pc wraps 0xFF -> 0x00 modulo 2^PC_W; no flag.
- ALU results are truncated to DATA_W. Carry is ignored.

## Timing
- Reset values: state IDLE, pc=0, imem_rd=0, imem_addr=0, rf_wr_en=0, rf_wr_addr=0, rf_wr_data=0, alu_op=0, busy=0, halted=0.
- Minimum latency is 4 cycles per instruction (FETCH, DECODE, EXEC, WB) when imem_valid arrives in the first FETCH cycle. Each wait cycle adds 1.
- In free-run, the next FETCH follows WB with no IDLE cycle.
- step while busy or halted: ignored, not queued.
- step and run both high in IDLE: one FETCH, no double-start.
- imem_valid outside FETCH: ignored.
- run deasserted mid-instruction: the instruction completes, then the FSM stops in IDLE.
- rst mid-instruction: aborts next cycle. No rf_wr_en pulse is issued for the aborted instruction.
- rf_wr_en is never high for more than 1 cycle per instruction.

## Structure
- Shared package isa_pkg holds:
  - OP_NOP, OP_LD, OP_JMP, OP_HALT constants;
  - the state encoding (IDLE, FETCH, DECODE, EXEC, WB, HALT);
  - the field bit positions.
- The ALU also uses OP_* from isa_pkg.
- One natural sub-module, instr_fields: combinational extraction of opcode/rd/rs/imm from the instruction register, including the LD rd-select rule.
- FSM, pc and the result register live in cpu_sequencer.

## Test plan
- LD: reset, run=1, mem[0]=0x1A3C, valid same cycle -> rf_wr_en at cycle 4, rf_wr_addr=0xA, rf_wr_data=0x3C, pc=1.
- ALU op: mem[1]=0x2021, rf r2=5, r1=3, alu_y=8 -> write r2=0x08. rd taken from bits[7:4], not bits[11:8].
- Step mode: run=0, two step pulses 2 cycles apart -> second pulse ignored; exactly one instruction executes; FSM returns to IDLE; busy=0.
- JMP/wrap: pc=0xFF with NOP -> pc=0x00. JMP 0xE040 -> pc=0x40, no rf_wr_en.
- HALT and fetch stall: imem_valid delayed 3 cycles -> imem_rd held, 7-cycle instruction. 0xF000 -> halted=1 and step ignored.
- Reset mid-EXEC of an LD -> no write, pc=0, state IDLE.
